// File: rtl/fifo_rd_stream.sv
// Read-side consumer after the async FIFO: issues rd_en, captures 1-cycle-latency read
// data into a 2-entry buffer and presents it as a framed valid/ready stream.
module fifo_rd_stream #(
  parameter int width   = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk_r,
  input  logic             reset,
  input  logic [width-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             rd_en,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [width-1:0]  buf_q [2];
  logic [width-1:0]  buf_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;

  logic              pop;
  logic [2:0]        level;

  // A read is only issued if the word it returns next cycle is guaranteed a slot,
  // counting the word already in flight and any slot freed by this cycle's pop.
  always_comb begin
    pop   = (occ_q != 2'd0) & m_ready;
    level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    rd_en = reset & ~fifo_empty & (level < 3'd2);

    occ_d     = level[1:0];
    infl_d    = rd_en;
    buf_d     = buf_q;
    head_d    = head_q;
    tail_d    = tail_q;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;

    if (infl_q) begin
      buf_d[tail_q] = fifo_data;
      tail_d        = ~tail_q;
    end

    if (pop) begin
      head_d = ~head_q;
      if (beat_q == LAST_BEAT) begin
        beat_d    = '0;
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_r) begin
    if (!reset) begin
      occ_q     <= 2'd0;
      infl_q    <= 1'b0;
      beat_q    <= '0;
      pkt_cnt_q <= '0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      buf_q     <= buf_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[head_q];
  assign m_last  = m_valid & (beat_q == LAST_BEAT);
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO with 1-cycle read latency feeds the
// DUT while a scoreboard and beat/packet model check every accepted word.
module tb_fifo_rd_stream;

  logic        clk_r;
  logic        reset;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  pkt_cnt;

  fifo_rd_stream #(.width(16), .PKT_LEN(8), .CNT_W(4)) dut (
    .clk_r(clk_r), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_words[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pop_count, rd_count;
  int          first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  logic [15:0] first_pop_data;
  logic [2:0]  exp_beat = 3'd0;
  logic [3:0]  exp_pkt = 4'd0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        obs_rd_en, obs_valid, obs_last;
  logic [15:0] obs_data;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic clearPhase();
    pop_count = 0; rd_count = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    last_words.delete();
  endtask

  // One clk_r cycle: drive inputs, check what the DUT presents to the coming edge, then
  // return the word read by the FIFO model on the following negedge (1-cycle latency).
  task automatic applyStimulus(input bit ready, input bit hold_empty);
    logic [15:0] pending;
    bit          pending_v;
    logic [15:0] exp_word;
    pending_v  = 1'b0;
    pending    = '0;
    m_ready    = ready;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    obs_rd_en = rd_en; obs_valid = m_valid; obs_data = m_data; obs_last = m_last;

    checkOutput("rd_en_gate", {31'd0, rd_en & (fifo_empty | ~reset)}, 32'd0);
    checkOutput("pkt_cnt", {28'd0, pkt_cnt}, {28'd0, exp_pkt});
    if (m_valid) checkOutput("m_last", {31'd0, m_last}, {31'd0, exp_beat == 3'd7});
    else         checkOutput("m_last_idle", {31'd0, m_last}, 32'd0);
    if (prev_stall) begin
      checkOutput("stall_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("stall_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("pop_unexpected", 32'd1, 32'd0);
      end else begin
        exp_word = exp_q.pop_front();
        checkOutput("m_data", {16'd0, m_data}, {16'd0, exp_word});
      end
      if (first_pop_cyc < 0) begin first_pop_cyc = cyc; first_pop_data = m_data; end
      last_pop_cyc = cyc;
      pop_count++;
      if (m_last) last_words.push_back(m_data);
      if (exp_beat == 3'd7) begin exp_beat = 3'd0; exp_pkt = exp_pkt + 4'd1; end
      else exp_beat = exp_beat + 3'd1;
    end

    if (rd_en && fifo_q.size() > 0) begin
      pending   = fifo_q.pop_front();
      pending_v = 1'b1;
      exp_q.push_back(pending);
      rd_count++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end

    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;

    @(posedge clk_r);
    if (!reset) begin
      exp_q.delete(); exp_beat = 3'd0; exp_pkt = 4'd0; prev_stall = 1'b0;
    end
    @(negedge clk_r);
    if (pending_v) fifo_data = pending;
    cyc++;
  endtask

  initial begin
    reset = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    repeat (2) @(negedge clk_r);

    // Reset held with a non-empty FIFO: nothing may be read or presented.
    for (int i = 0; i < 16; i++) fifo_q.push_back(16'(i));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("reset_rd_en", {31'd0, obs_rd_en}, 32'd0);
      checkOutput("reset_valid", {31'd0, obs_valid}, 32'd0);
      checkOutput("reset_last", {31'd0, obs_last}, 32'd0);
      checkOutput("reset_data", {16'd0, obs_data}, 32'd0);
    end
    checkOutput("reset_pkt_cnt", {28'd0, pkt_cnt}, 32'd0);

    // Streaming 16 words with m_ready high.
    reset = 1'b1;
    clearPhase();
    applyStimulus(1'b1, 1'b0);
    checkOutput("release_rd_en", {31'd0, obs_rd_en}, 32'd1);
    for (int i = 0; i < 60 && pop_count < 16; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("stream_pops", pop_count, 32'd16);
    checkOutput("stream_latency", first_valid_cyc - first_rd_cyc, 32'd2);
    checkOutput("stream_span", last_pop_cyc - first_pop_cyc, 32'd15);
    checkOutput("stream_last_count", last_words.size(), 32'd2);
    checkOutput("stream_last0", {16'd0, (last_words.size() > 0) ? last_words[0] : 16'hdead}, 32'h7);
    checkOutput("stream_last1", {16'd0, (last_words.size() > 1) ? last_words[1] : 16'hdead}, 32'hf);
    checkOutput("stream_pkt_cnt", {28'd0, pkt_cnt}, 32'd2);

    // Back-pressure: only two reads fill the buffer, head word held.
    clearPhase();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'h0100 + 16'(i));
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("bp_rd_pulses", rd_count, 32'd2);
    checkOutput("bp_valid", {31'd0, obs_valid}, 32'd1);
    checkOutput("bp_data", {16'd0, obs_data}, 32'h0100);
    checkOutput("bp_rd_en_full", {31'd0, obs_rd_en}, 32'd0);
    checkOutput("bp_fifo_left", fifo_q.size(), 32'd6);
    clearPhase();
    for (int i = 0; i < 40 && pop_count < 8; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("bp_pops", pop_count, 32'd8);
    checkOutput("bp_span", last_pop_cyc - first_pop_cyc, 32'd7);
    checkOutput("bp_last", {16'd0, (last_words.size() > 0) ? last_words[0] : 16'hdead}, 32'h0107);
    checkOutput("bp_pkt_cnt", {28'd0, pkt_cnt}, 32'd3);

    // FIFO runs dry mid-packet, then resumes.
    clearPhase();
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'h0200 + 16'(i));
    repeat (8) applyStimulus(1'b1, 1'b0);
    checkOutput("empty_pops", pop_count, 32'd3);
    checkOutput("empty_reads", rd_count, 32'd3);
    checkOutput("empty_valid", {31'd0, obs_valid}, 32'd0);
    checkOutput("empty_rd_en", {31'd0, obs_rd_en}, 32'd0);
    clearPhase();
    for (int i = 3; i < 8; i++) fifo_q.push_back(16'h0200 + 16'(i));
    for (int i = 0; i < 30 && pop_count < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("resume_pops", pop_count, 32'd5);
    checkOutput("resume_last", {16'd0, (last_words.size() > 0) ? last_words[0] : 16'hdead}, 32'h0207);
    checkOutput("resume_pkt_cnt", {28'd0, pkt_cnt}, 32'd4);

    // Random ready and FIFO-empty gaps over 1000 words; pkt_cnt wraps through 4 bits.
    clearPhase();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(16'($urandom));
    for (int i = 0; i < 8000 && pop_count < 1000; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
    checkOutput("rand_pops", pop_count, 32'd1000);
    checkOutput("rand_pkt_cnt", {28'd0, pkt_cnt}, 32'd1);
    checkOutput("rand_scoreboard_left", exp_q.size(), 32'd0);

    // Reset with one word buffered and one in flight: both are discarded.
    clearPhase();
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'h0300 + 16'(i));
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("mid_reads", rd_count, 32'd2);
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("mid_reset_valid", {31'd0, obs_valid}, 32'd0);
    reset = 1'b1;
    clearPhase();
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_release_valid", {31'd0, obs_valid}, 32'd0);
    checkOutput("mid_release_rd_en", {31'd0, obs_rd_en}, 32'd1);
    for (int i = 0; i < 30 && pop_count < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("mid_pops", pop_count, 32'd4);
    checkOutput("mid_first_word", {16'd0, first_pop_data}, 32'h0302);
    checkOutput("mid_pkt_cnt", {28'd0, pkt_cnt}, 32'd0);
    checkOutput("mid_no_last", last_words.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
